// File: rtl/bp_pkg.sv
// bp_pkg: shared entry layout, counter constants and saturating helpers for the branch predictor
package bp_pkg;
  localparam int DEF_PC_W = 30;
  localparam int DEF_TAG_W = 8;
  localparam int DEF_CTR_W = 2;
  localparam logic [DEF_CTR_W-1:0] CTR_WEAK_T = DEF_CTR_W'(1 << (DEF_CTR_W - 1));
  localparam logic [DEF_CTR_W-1:0] CTR_WEAK_NT = DEF_CTR_W'((1 << (DEF_CTR_W - 1)) - 1);
  typedef struct packed {
    logic valid;
    logic [DEF_TAG_W-1:0] tag;
    logic [DEF_CTR_W-1:0] ctr;
    logic [DEF_PC_W-1:0] target;
  } bht_entry_t;
  function automatic logic [15:0] ctr_inc(input logic [15:0] c, input int w);
    return c == (16'd1 << w) - 16'd1 ? c : c + 16'd1;
  endfunction
  function automatic logic [15:0] ctr_dec(input logic [15:0] c);
    return c == 16'd0 ? c : c - 16'd1;
  endfunction
endpackage

// File: rtl/branch_predictor_bht_if.sv
// branch_predictor_bht_if: fetch lookup, EX update and perf counter bundle
interface branch_predictor_bht_if #(parameter int PC_W = 30, parameter int GH_W = 1);
  logic if_valid, if_stall;
  logic [PC_W-1:0] if_pc;
  logic pred_hit, pred_taken;
  logic [PC_W-1:0] pred_target;
  logic [GH_W-1:0] pred_ghr;
  logic upd_valid, upd_taken, upd_mispredict;
  logic [PC_W-1:0] upd_pc, upd_target;
  logic [GH_W-1:0] upd_ghr;
  logic [31:0] perf_lookups, perf_mispred;
  modport master (
    output if_valid, if_stall, if_pc, upd_valid, upd_pc, upd_ghr, upd_taken, upd_target, upd_mispredict,
    input pred_hit, pred_taken, pred_target, pred_ghr, perf_lookups, perf_mispred
  );
  modport slave (
    input if_valid, if_stall, if_pc, upd_valid, upd_pc, upd_ghr, upd_taken, upd_target, upd_mispredict,
    output pred_hit, pred_taken, pred_target, pred_ghr, perf_lookups, perf_mispred
  );
endinterface

// File: rtl/bp_sat_ctr.sv
// bp_sat_ctr: next value of a saturating direction counter
module bp_sat_ctr import bp_pkg::*; #(parameter int CTR_W = 2) (
  input  logic             upd,
  input  logic             taken,
  input  logic [CTR_W-1:0] ctr,
  output logic [CTR_W-1:0] nxt
);
  always_comb nxt = !upd ? ctr : taken ? CTR_W'(ctr_inc(16'(ctr), CTR_W)) : CTR_W'(ctr_dec(16'(ctr)));
endmodule

// File: rtl/branch_predictor_bht.sv
// branch_predictor_bht: tagged direct-mapped BHT+BTB with optional gshare history
module branch_predictor_bht import bp_pkg::*; #(
  parameter int PC_W = 30,
  parameter int ENTRIES = 64,
  parameter int TAG_W = 8,
  parameter int CTR_W = 2,
  parameter int HIST_W = 0
) (
  input logic clk,
  input logic rst,
  branch_predictor_bht_if.slave bus
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int GH_W = HIST_W > 0 ? HIST_W : 1;
  localparam logic [CTR_W-1:0] WEAK_T = CTR_W'(1 << (CTR_W - 1));
  localparam logic [CTR_W-1:0] WEAK_NT = CTR_W'((1 << (CTR_W - 1)) - 1);
  typedef struct packed {
    logic valid;
    logic [TAG_W-1:0] tag;
    logic [CTR_W-1:0] ctr;
    logic [PC_W-1:0] target;
  } entry_t;
  entry_t tbl [ENTRIES];
  logic [GH_W-1:0] ghr, ghr_nxt;
  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic up_hit, adv, mis;
  logic [CTR_W-1:0] ctr_nxt;
  always_comb begin
    lk_idx = bus.if_pc[IDX_W-1:0] ^ (HIST_W > 0 ? IDX_W'(ghr) : '0);
    up_idx = bus.upd_pc[IDX_W-1:0] ^ (HIST_W > 0 ? IDX_W'(bus.upd_ghr) : '0);
    lk_tag = bus.if_pc[IDX_W+TAG_W-1:IDX_W];
    up_tag = bus.upd_pc[IDX_W+TAG_W-1:IDX_W];
    up_hit = tbl[up_idx].valid && tbl[up_idx].tag == up_tag;
    bus.pred_hit = tbl[lk_idx].valid && tbl[lk_idx].tag == lk_tag;
    bus.pred_taken = bus.pred_hit && tbl[lk_idx].ctr[CTR_W-1];
    bus.pred_target = bus.pred_hit ? tbl[lk_idx].target : '0;
    bus.pred_ghr = ghr;
    mis = bus.upd_valid && bus.upd_mispredict;
    adv = bus.if_valid && !bus.if_stall && bus.pred_hit;
    // repair from the branch's own snapshot beats the speculative shift
    ghr_nxt = HIST_W == 0 ? '0
            : mis ? (bus.upd_ghr << 1) | GH_W'(bus.upd_taken)
            : adv ? (ghr << 1) | GH_W'(bus.pred_taken)
            : ghr;
  end
  bp_sat_ctr #(.CTR_W(CTR_W)) u_ctr (.upd(up_hit), .taken(bus.upd_taken), .ctr(tbl[up_idx].ctr), .nxt(ctr_nxt));
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) tbl[i] <= '{valid: 1'b0, tag: '0, ctr: WEAK_NT, target: '0};
      ghr <= '0;
      bus.perf_lookups <= '0;
      bus.perf_mispred <= '0;
    end else begin
      if (bus.upd_valid && (up_hit || bus.upd_taken))
        tbl[up_idx] <= '{valid: 1'b1, tag: up_tag, ctr: up_hit ? ctr_nxt : WEAK_T,
                         target: bus.upd_taken ? bus.upd_target : tbl[up_idx].target};
      ghr <= ghr_nxt;
      bus.perf_lookups <= bus.perf_lookups + 32'(adv);
      bus.perf_mispred <= bus.perf_mispred + 32'(mis);
    end
  if (PC_W > IDX_W + TAG_W) begin : g_unused
    logic unused_pc;
    assign unused_pc = ^{bus.if_pc[PC_W-1:IDX_W+TAG_W], bus.upd_pc[PC_W-1:IDX_W+TAG_W]};
  end
endmodule

// File: tb/tb_branch_predictor_bht.sv
// tb_branch_predictor_bht: vector table on a bimodal instance plus gshare and reset sequences
module tb_branch_predictor_bht;
  typedef struct {
    logic uv;
    logic [29:0] upc;
    logic ut;
    logic [29:0] utg;
    logic [29:0] lpc;
    logic hit, tk;
    logic [29:0] tg;
  } vec_t;
  logic clk = 0, rst = 0;
  int n_vec = 0, n_err = 0, vi = 0, exp_look = 0;
  vec_t vt [16];
  vec_t sb [$];
  vec_t e;
  always #5 clk = ~clk;
  branch_predictor_bht_if #(.PC_W(30), .GH_W(1)) b ();
  branch_predictor_bht_if #(.PC_W(30), .GH_W(4)) g ();
  branch_predictor_bht #(.HIST_W(0)) dut_b (.clk(clk), .rst(rst), .bus(b.slave));
  branch_predictor_bht #(.HIST_W(4)) dut_g (.clk(clk), .rst(rst), .bus(g.slave));

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] x);
    n_vec++;
    if (a !== x) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", n, a, x);
    end
  endtask

  function automatic vec_t mk(bit uv, int upc, bit ut, int utg, int lpc, bit h, bit t, int tg);
    return '{uv, 30'(upc), ut, 30'(utg), 30'(lpc), h, t, 30'(tg)};
  endfunction

  task automatic idle();
    b.if_valid = 0; b.if_stall = 0; b.if_pc = '0; b.upd_valid = 0; b.upd_pc = '0; b.upd_ghr = '0;
    b.upd_taken = 0; b.upd_target = '0; b.upd_mispredict = 0;
    g.if_valid = 0; g.if_stall = 0; g.if_pc = '0; g.upd_valid = 0; g.upd_pc = '0; g.upd_ghr = '0;
    g.upd_taken = 0; g.upd_target = '0; g.upd_mispredict = 0;
  endtask

  always @(negedge clk)
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk($sformatf("vec%0d_hit", vi), 64'(b.pred_hit), 64'(e.hit));
      chk($sformatf("vec%0d_taken", vi), 64'(b.pred_taken), 64'(e.tk));
      chk($sformatf("vec%0d_target", vi), 64'(b.pred_target), 64'(e.tg));
      vi++;
    end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vt[0]  = mk(0, 'h000, 0, 'h000, 'h100, 0, 0, 'h000);
    vt[1]  = mk(1, 'h100, 1, 'h200, 'h100, 1, 1, 'h200);
    vt[2]  = mk(1, 'h100, 0, 'h999, 'h100, 1, 0, 'h200);
    vt[3]  = mk(1, 'h100, 0, 'h000, 'h100, 1, 0, 'h200);
    vt[4]  = mk(1, 'h100, 0, 'h000, 'h100, 1, 0, 'h200);
    vt[5]  = mk(1, 'h100, 1, 'h300, 'h100, 1, 0, 'h300);
    vt[6]  = mk(1, 'h100, 1, 'h300, 'h100, 1, 1, 'h300);
    vt[7]  = mk(1, 'h100, 1, 'h300, 'h100, 1, 1, 'h300);
    vt[8]  = mk(1, 'h100, 1, 'h300, 'h100, 1, 1, 'h300);
    vt[9]  = mk(1, 'h100, 0, 'h000, 'h100, 1, 1, 'h300);
    vt[10] = mk(1, 'h100, 0, 'h000, 'h100, 1, 0, 'h300);
    vt[11] = mk(1, 'h040, 1, 'h111, 'h040, 1, 1, 'h111);
    vt[12] = mk(1, 'h440, 1, 'h222, 'h040, 0, 0, 'h000);
    vt[13] = mk(0, 'h000, 0, 'h000, 'h440, 1, 1, 'h222);
    vt[14] = mk(0, 'h000, 0, 'h000, 'h100, 0, 0, 'h000);
    vt[15] = mk(1, 'h005, 0, 'h055, 'h005, 0, 0, 'h000);
    idle();
    #2 rst = 1;
    b.if_pc = 30'h100;
    #1;
    chk("rst_hit", 64'(b.pred_hit), 0);
    chk("rst_taken", 64'(b.pred_taken), 0);
    chk("rst_target", 64'(b.pred_target), 0);
    chk("rst_perf_lookups", 64'(b.perf_lookups), 0);
    chk("rst_perf_mispred", 64'(b.perf_mispred), 0);
    chk("rst_ghr", 64'(g.pred_ghr), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) begin
      b.upd_valid = vt[i].uv; b.upd_pc = vt[i].upc; b.upd_taken = vt[i].ut; b.upd_target = vt[i].utg;
      b.if_valid = 0;
      @(posedge clk); #1;
      b.upd_valid = 0; b.if_valid = 1; b.if_pc = vt[i].lpc;
      sb.push_back(vt[i]);
      exp_look += int'(vt[i].hit);
      @(posedge clk); #1;
      b.if_valid = 0;
    end
    chk("sb_drained", 64'(sb.size()), 0);
    chk("perf_lookups", 64'(b.perf_lookups), 64'(exp_look));
    chk("perf_mispred", 64'(b.perf_mispred), 0);
    b.upd_valid = 1; b.upd_pc = 30'h007; b.upd_taken = 1; b.upd_target = 30'h077; b.if_pc = 30'h007;
    @(negedge clk) chk("nobypass_hit", 64'(b.pred_hit), 0);
    @(posedge clk); #1;
    b.upd_valid = 0;
    @(negedge clk);
    chk("after_upd_hit", 64'(b.pred_hit), 1);
    chk("after_upd_target", 64'(b.pred_target), 'h77);
    @(posedge clk); #1;
    b.if_pc = 30'h440; b.upd_valid = 1; b.upd_pc = 30'h008; b.upd_taken = 1; b.upd_target = 30'h088;
    @(negedge clk);
    chk("prerst_hit", 64'(b.pred_hit), 1);
    rst = 1;
    #1;
    chk("midrst_hit", 64'(b.pred_hit), 0);
    chk("midrst_taken", 64'(b.pred_taken), 0);
    chk("midrst_target", 64'(b.pred_target), 0);
    chk("midrst_perf_lookups", 64'(b.perf_lookups), 0);
    @(posedge clk);
    @(negedge clk);
    rst = 0; b.upd_valid = 0; b.if_pc = 30'h008;
    #1 chk("rst_noalloc_hit", 64'(b.pred_hit), 0);
    b.if_pc = 30'h440;
    #1 chk("rst_cleared_hit", 64'(b.pred_hit), 0);
    @(posedge clk); #1;
    g.upd_valid = 1; g.upd_pc = 30'h100; g.upd_ghr = 4'b0000; g.upd_taken = 1; g.upd_target = 30'h200;
    @(posedge clk); #1;
    g.upd_valid = 0; g.if_valid = 1; g.if_pc = 30'h100;
    @(negedge clk);
    chk("g_hit", 64'(g.pred_hit), 1);
    chk("g_taken", 64'(g.pred_taken), 1);
    chk("g_ghr0", 64'(g.pred_ghr), 0);
    @(posedge clk); #1;
    g.if_valid = 0;
    chk("g_ghr_shift", 64'(g.pred_ghr), 4'b0001);
    g.upd_valid = 1; g.upd_pc = 30'h100; g.upd_ghr = 4'b0001; g.upd_taken = 1; g.upd_target = 30'h300;
    @(posedge clk); #1;
    g.upd_pc = 30'h3F0; g.upd_ghr = 4'b1010; g.upd_taken = 0; g.upd_target = '0; g.upd_mispredict = 1;
    g.if_valid = 1; g.if_pc = 30'h100;
    @(negedge clk);
    chk("g_xor_hit", 64'(g.pred_hit), 1);
    chk("g_xor_target", 64'(g.pred_target), 'h300);
    @(posedge clk); #1;
    g.upd_valid = 0; g.upd_mispredict = 0; g.if_valid = 0;
    chk("g_repair", 64'(g.pred_ghr), 4'b0100);
    chk("g_perf_mispred", 64'(g.perf_mispred), 1);
    chk("g_perf_lookups", 64'(g.perf_lookups), 2);
    g.upd_valid = 1; g.upd_pc = 30'h100; g.upd_ghr = 4'b0100; g.upd_taken = 1; g.upd_target = 30'h400;
    @(posedge clk); #1;
    g.upd_valid = 0; g.if_valid = 1; g.if_stall = 1; g.if_pc = 30'h100;
    @(negedge clk);
    chk("g_stall_hit", 64'(g.pred_hit), 1);
    chk("g_stall_target", 64'(g.pred_target), 'h400);
    @(posedge clk); #1;
    chk("g_stall_ghr", 64'(g.pred_ghr), 4'b0100);
    chk("g_stall_lookups", 64'(g.perf_lookups), 2);
    g.if_stall = 0;
    @(negedge clk) chk("g_nostall_hit", 64'(g.pred_hit), 1);
    @(posedge clk); #1;
    g.if_valid = 0;
    chk("g_nostall_ghr", 64'(g.pred_ghr), 4'b1001);
    chk("g_nostall_lookups", 64'(g.perf_lookups), 3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
